// File: rtl/io_bridge_pkg.sv
// Shared definitions for the host/processor I/O bridge: word width,
// presentation state encoding and a saturating-increment helper.
package io_bridge_pkg;

  localparam int WORD_W = 16;
  localparam int DROP_W = 8;

  // Presentation register state: nothing offered, or a word offered.
  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } pres_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read (no added read latency),
// registered occupancy count and full/empty flags derived from that count.
// Pushes while full and pops while empty are ignored; reset dominates both.
module sync_fifo
  import io_bridge_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = rst_ni & push_i & ~full_o;
  assign do_pop  = rst_ni & pop_i & ~empty_o;

  // Next pointer/count values; pointers wrap naturally since DEPTH is 2^AW.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because the count guards reads.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/io_host_bridge.sv
// Host <-> processor I/O bridge.
//  - Input path: host words queue in a FIFO and are presented one at a time
//    to the processor; in_ack retires the presented word.
//  - Output path: every change of the processor's main_output is captured
//    into a second FIFO that the host drains; words arriving while that FIFO
//    is full are dropped and flagged by the sticky overflow bit.
// Optional build macro IO_HOST_BRIDGE_DROPCNT_EN adds an 8-bit saturating
// drop_count output counting dropped capture words.
module io_host_bridge
  import io_bridge_pkg::*;
#(
  parameter int DEPTH = 4  // power of two, >= 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [WORD_W-1:0] host_in_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  output logic [WORD_W-1:0] main_input,
  output logic              in_empty,
  input  logic              in_ack,
  input  logic [WORD_W-1:0] main_output,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
`ifdef IO_HOST_BRIDGE_DROPCNT_EN
  ,
  output logic [DROP_W-1:0] drop_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Input path signals
  logic [WORD_W-1:0] in_head;
  logic              in_full, in_fifo_empty, in_push, in_pop;
  logic [CW-1:0]     in_count;
  pres_state_e       state_q, state_d;
  logic [WORD_W-1:0] pres_q, pres_d;

  // Output path signals
  logic [WORD_W-1:0] prev_q;
  logic              out_full, out_fifo_empty, out_change, out_drop;
  logic [CW-1:0]     out_count;
  logic              overflow_q, overflow_d;

  // Counts are exported by the FIFO but this block only needs the flags.
  logic [2*CW-1:0]   unused_counts;
  assign unused_counts = {in_count, out_count};

  // ---------------- input path ----------------
  // Ready follows the registered full flag, so a same-cycle pop never frees
  // a slot for a push; held low throughout reset.
  assign host_in_ready = reset & ~in_full;
  assign in_push       = host_in_valid & host_in_ready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_in_fifo (
    .clk_i   (CLK),
    .rst_ni  (reset),
    .push_i  (in_push),
    .data_i  (host_in_data),
    .pop_i   (in_pop),
    .data_o  (in_head),
    .full_o  (in_full),
    .empty_o (in_fifo_empty),
    .count_o (in_count)
  );

  // Presentation FSM: load the FIFO head when idle, reload on ack if more
  // words are waiting, otherwise fall back to EMPTY keeping the last value.
  always_comb begin
    state_d = state_q;
    pres_d  = pres_q;
    in_pop  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (!in_fifo_empty) begin
          in_pop  = 1'b1;
          pres_d  = in_head;
          state_d = LOADED;
        end
      end
      LOADED: begin
        if (in_ack) begin
          if (!in_fifo_empty) begin
            in_pop = 1'b1;
            pres_d = in_head;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Presentation state and register.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= EMPTY;
      pres_q  <= '0;
    end else begin
      state_q <= state_d;
      pres_q  <= pres_d;
    end
  end

  assign main_input = pres_q;
  assign in_empty   = (state_q == EMPTY);

  // ---------------- output path ----------------
  // A change is any cycle where main_output differs from last cycle's value.
  assign out_change = (main_output != prev_q);
  assign out_drop   = out_change & out_full;
  assign overflow_d = overflow_q | out_drop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_out_fifo (
    .clk_i   (CLK),
    .rst_ni  (reset),
    .push_i  (out_change),
    .data_i  (main_output),
    .pop_i   (out_ready),
    .data_o  (out_data),
    .full_o  (out_full),
    .empty_o (out_fifo_empty),
    .count_o (out_count)
  );

  assign out_valid = ~out_fifo_empty;

  // Previous-value register and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      prev_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= main_output;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

`ifdef IO_HOST_BRIDGE_DROPCNT_EN
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  assign drop_cnt_d = out_drop ? sat_inc(drop_cnt_q) : drop_cnt_q;

  // Saturating count of dropped capture words.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  // No drop counter in this build; overflow alone reports lost words.
`endif

endmodule

// File: tb/tb_io_host_bridge.sv
// Directed testbench for io_host_bridge with scoreboard queues: stimulus
// pushes expected words, negedge monitors pop and compare when the DUT
// presents a new input word or hands a captured word to the host.
module tb_io_host_bridge;

  logic        CLK = 1'b0;
  logic        reset;
  logic [15:0] host_in_data;
  logic        host_in_valid;
  logic        host_in_ready;
  logic [15:0] main_input;
  logic        in_empty;
  logic        in_ack;
  logic [15:0] main_output;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
`ifdef IO_HOST_BRIDGE_DROPCNT_EN
  logic [7:0]  drop_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_in[$];
  logic [15:0] exp_out[$];

  logic was_empty = 1'b1;
  logic ack_pend  = 1'b0;

  always #5 CLK = ~CLK;

  io_host_bridge #(.DEPTH(4)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .host_in_data  (host_in_data),
    .host_in_valid (host_in_valid),
    .host_in_ready (host_in_ready),
    .main_input    (main_input),
    .in_empty      (in_empty),
    .in_ack        (in_ack),
    .main_output   (main_output),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overflow      (overflow)
`ifdef IO_HOST_BRIDGE_DROPCNT_EN
    , .drop_count  (drop_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: a new presentation appears after an idle period or after an ack
  // of a loaded word; every host pop hands over the head of the output FIFO.
  always @(negedge CLK) begin
    if (!reset) begin
      was_empty = 1'b1;
      ack_pend  = 1'b0;
    end else begin
      if (!in_empty && (was_empty || ack_pend)) begin
        if (exp_in.size() == 0) begin
          total++; bad++;
          $display("FAIL present_extra: got %0h expected none", main_input);
        end else begin
          chk("present", main_input, exp_in.pop_front());
        end
      end
      was_empty = in_empty;
      ack_pend  = in_ack && !in_empty;
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          total++; bad++;
          $display("FAIL capture_extra: got %0h expected none", out_data);
        end else begin
          chk("capture", out_data, exp_out.pop_front());
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] seq3 [3];
    reset = 1'b0; host_in_data = '0; host_in_valid = 1'b0; in_ack = 1'b0;
    main_output = '0; out_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_in_empty", in_empty, 1);
    chk("rst_main_input", main_input, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ready_low", host_in_ready, 0);
`ifdef IO_HOST_BRIDGE_DROPCNT_EN
    chk("rst_drop_count", drop_count, 0);
`endif
    reset = 1'b1;
    #1;
    chk("ready_after_release", host_in_ready, 1);
    tick();

    // Single push with idle processor: visible after the following edge
    host_in_data = 16'h1234; host_in_valid = 1'b1; exp_in.push_back(16'h1234);
    tick();
    host_in_valid = 1'b0;
    chk("single_not_yet", in_empty, 1);
    tick();
    chk("single_loaded", in_empty, 0);
    chk("single_value", main_input, 16'h1234);
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    chk("single_acked_empty", in_empty, 1);
    chk("single_held", main_input, 16'h1234);
    in_ack = 1'b1; tick(); in_ack = 1'b0; tick();
    chk("ack_in_empty_ignored", in_empty, 1);
    chk("ack_in_empty_held", main_input, 16'h1234);

    // Input FIFO fill: word 1 presented, 2..5 stored, 6 refused until ack
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("fill_ready_%0d", k), host_in_ready, 1);
      host_in_data = 16'h1000 + 16'(k); host_in_valid = 1'b1;
      exp_in.push_back(16'h1000 + 16'(k));
      tick();
    end
    host_in_data = 16'h1006;
    chk("fill_full_ready", host_in_ready, 0);
    chk("fill_presented", main_input, 16'h1001);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fill_hold_ready", host_in_ready, 0);
    end
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    chk("fill_after_ack_ready", host_in_ready, 1);
    chk("fill_after_ack_value", main_input, 16'h1002);
    exp_in.push_back(16'h1006);
    tick();
    host_in_valid = 1'b0;
    chk("fill_refull_ready", host_in_ready, 0);
    for (int k = 0; k < 5; k++) begin
      in_ack = 1'b1; tick(); in_ack = 1'b0; tick();
    end
    chk("fill_drained_empty", in_empty, 1);
    chk("fill_drained_held", main_input, 16'h1006);

    // Back-to-back consumption over three queued words
    seq3[0] = 16'h2001; seq3[1] = 16'h2002; seq3[2] = 16'h2003;
    for (int k = 0; k < 3; k++) begin
      host_in_data = seq3[k]; host_in_valid = 1'b1; exp_in.push_back(seq3[k]);
      tick();
    end
    host_in_valid = 1'b0;
    tick();
    chk("b2b_first", main_input, 16'h2001);
    in_ack = 1'b1;
    tick();
    chk("b2b_step1_loaded", in_empty, 0);
    chk("b2b_step1_value", main_input, 16'h2002);
    tick();
    chk("b2b_step2_loaded", in_empty, 0);
    chk("b2b_step2_value", main_input, 16'h2003);
    tick();
    in_ack = 1'b0;
    chk("b2b_end_empty", in_empty, 1);
    chk("b2b_end_held", main_input, 16'h2003);

    // Output capture: 0 -> 5 -> 5 -> 9 yields exactly 5 then 9
    out_ready = 1'b1;
    main_output = 16'h0000; tick();
    main_output = 16'h0005; exp_out.push_back(16'h0005); tick();
    main_output = 16'h0005; tick();
    main_output = 16'h0009; exp_out.push_back(16'h0009); tick();
    repeat (4) tick();
    chk("capture_all_seen", exp_out.size(), 0);
    chk("capture_idle_valid", out_valid, 0);

    // Output overflow: five changes with no host pops, fifth dropped
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      main_output = 16'h0030 + 16'(k);
      if (k <= 4) exp_out.push_back(16'h0030 + 16'(k));
      tick();
      if (k == 4) chk("ovf_not_yet", overflow, 0);
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_valid", out_valid, 1);
`ifdef IO_HOST_BRIDGE_DROPCNT_EN
    chk("ovf_drop_count", drop_count, 1);
`endif
    tick();
    out_ready = 1'b1;
    repeat (6) tick();
    out_ready = 1'b0;
    chk("ovf_drained", exp_out.size(), 0);
    chk("ovf_sticky", overflow, 1);

    // Reset mid-operation with both FIFOs holding two words
    for (int k = 1; k <= 3; k++) begin
      host_in_data = 16'h3000 + 16'(k); host_in_valid = 1'b1;
      exp_in.push_back(16'h3000 + 16'(k));
      tick();
    end
    host_in_valid = 1'b0;
    main_output = 16'h0041; tick();
    main_output = 16'h0042; tick();
    tick();
    chk("pre_reset_loaded", in_empty, 0);
    chk("pre_reset_out_valid", out_valid, 1);
    reset = 1'b0; in_ack = 1'b1; out_ready = 1'b1; main_output = 16'h0000;
    host_in_valid = 1'b1; host_in_data = 16'h3fff;
    exp_in.delete(); exp_out.delete();
    #1;
    chk("mid_reset_ready_low", host_in_ready, 0);
    tick(); tick();
    chk("mid_reset_ready_still_low", host_in_ready, 0);
    reset = 1'b1; in_ack = 1'b0; out_ready = 1'b0; host_in_valid = 1'b0;
    #1;
    chk("post_reset_ready", host_in_ready, 1);
    tick();
    chk("post_reset_in_empty", in_empty, 1);
    chk("post_reset_out_valid", out_valid, 0);
    chk("post_reset_overflow", overflow, 0);
    chk("post_reset_main_input", main_input, 0);
`ifdef IO_HOST_BRIDGE_DROPCNT_EN
    chk("post_reset_drop_count", drop_count, 0);
`endif
    repeat (3) tick();
    chk("post_reset_stay_empty", in_empty, 1);

    chk("in_queue_drained", exp_in.size(), 0);
    chk("out_queue_drained", exp_out.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
